// File: rtl/fast2slow_pkg.sv
// Shared definitions for the fast-to-slow event handshake sender and its
// slow-side receiver: FSM encodings and default parameter values.
package fast2slow_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    ACK_LO = 2'd2
  } state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CW_DEF          = 3;

endpackage

// File: rtl/fast2slow_if.sv
// Event/handshake bundle between the fast-domain event source, the sender
// and the slow-domain receiver (ack_async is asynchronous to the sender clock).
interface fast2slow_if #(
  parameter int CW = 3
) ();

  logic          sig_in;
  logic          ack_async;
  logic          ovf_clr;
  logic          req;
  logic          busy;
  logic [CW-1:0] pend_cnt;
  logic          ovf;

  modport master (
    output sig_in, ack_async, ovf_clr,
    input  req, busy, pend_cnt, ovf
  );

  modport slave (
    input  sig_in, ack_async, ovf_clr,
    output req, busy, pend_cnt, ovf
  );

endinterface

// File: rtl/fast2slow_sync_cell.sv
// Single-bit multi-flop synchronizer with asynchronous active-low clear.
// Used for ack on the fast side and for req on the slow side.
module sync_cell
  import fast2slow_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/fast2slow_tx.sv
// Fast-domain sender: turns each clk2 event pulse into one full 4-phase
// req/ack handshake, queueing events that arrive while one is in flight.
module fast2slow_tx
  import fast2slow_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic       clk2,
  input  logic       rstn,
  fast2slow_if.slave bus
);

  localparam logic [CW-1:0] PEND_MAX = {CW{1'b1}};

  logic          ack_sync;
  state_e        state_reg, state_next;
  logic          req_reg, busy_reg, ovf_reg;
  logic [CW-1:0] pend_cnt_reg, pend_cnt_next;
  logic          has_pend, launch, inc, dec, drop;

  sync_cell #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk2),
    .rstn (rstn),
    .d    (bus.ack_async),
    .q    (ack_sync)
  );

  always_comb begin
    has_pend   = (pend_cnt_reg != '0);
    launch     = 1'b0;
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        // A stray ack_sync here is deliberately ignored.
        if (bus.sig_in || has_pend) begin
          launch     = 1'b1;
          state_next = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_sync) state_next = ACK_LO;
      end
      ACK_LO: begin
        if (!ack_sync) begin
          if (bus.sig_in || has_pend) begin
            launch     = 1'b1;
            state_next = REQ_HI;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Pending events are older, so a launch drains them before sig_in.
    dec  = launch && has_pend;
    inc  = bus.sig_in && !(launch && !has_pend);
    drop = inc && !dec && (pend_cnt_reg == PEND_MAX);

    pend_cnt_next = pend_cnt_reg;
    if (inc && !dec && !drop) begin
      pend_cnt_next = pend_cnt_reg + CW'(1);
    end else if (dec && !inc) begin
      pend_cnt_next = pend_cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      req_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      pend_cnt_reg <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      req_reg      <= (state_next == REQ_HI);
      busy_reg     <= (state_next != IDLE);
      pend_cnt_reg <= pend_cnt_next;
      // Set beats clear when both happen in one cycle.
      if (drop) begin
        ovf_reg <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign bus.req      = req_reg;
  assign bus.busy     = busy_reg;
  assign bus.pend_cnt = pend_cnt_reg;
  assign bus.ovf      = ovf_reg;

endmodule

// File: tb/tb_fast2slow_tx.sv
// Directed bench for fast2slow_tx: a cycle-exact vector table with ack driven
// directly, then handshake sequences against a delayed-ack slow-side model.
module tb_fast2slow_tx;
  import fast2slow_pkg::*;

  localparam int CW = 3;

  typedef struct {
    logic sig;
    logic ack;
    logic clr;
    int   req;
    int   busy;
    int   pend;
    int   ovf;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  logic       clk2 = 1'b0;
  logic       clk_s = 1'b0;
  logic       rstn;
  logic       use_model = 1'b0;
  logic       ack_drv = 1'b0;
  logic [3:0] ack_sh;
  logic       req_q;
  int         rises = 0;
  int         tests = 0;
  int         fails = 0;

  fast2slow_if #(.CW(CW)) bus ();

  fast2slow_tx #(
    .SYNC_STAGES (2),
    .CW          (CW)
  ) dut (
    .clk2 (clk2),
    .rstn (rstn),
    .bus  (bus)
  );

  // clk2 edges at odd multiples of 5, slow edges at even times: never coincident.
  always #5 clk2 = ~clk2;
  always #12 clk_s = ~clk_s;

  // Slow-side receiver model: ack is req delayed four slow cycles.
  always @(posedge clk_s or negedge rstn) begin
    if (!rstn) ack_sh <= '0;
    else       ack_sh <= {ack_sh[2:0], bus.req};
  end
  assign bus.ack_async = use_model ? ack_sh[3] : ack_drv;

  always @(posedge clk2) begin
    if (bus.req && !req_q) rises <= rises + 1;
    req_q <= bus.req;
  end

  always @(negedge clk2) begin
    if (rstn === 1'b1)
      assert (!(!bus.busy && dut.ack_sync)) else $error("protocol: ack_sync high while idle");
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int r, input int b, input int p, input int o);
    chk({tag, "_req"},  int'(bus.req),      r);
    chk({tag, "_busy"}, int'(bus.busy),     b);
    chk({tag, "_pend"}, int'(bus.pend_cnt), p);
    chk({tag, "_ovf"},  int'(bus.ovf),      o);
  endtask

  task automatic cyc(input logic s, input logic a, input logic c);
    @(negedge clk2);
    bus.sig_in  = s;
    ack_drv     = a;
    bus.ovf_clr = c;
    @(posedge clk2);
    #1;
  endtask

  task automatic handshake_direct(input string nm);
    bit fell = 0;
    bit rose = 0;
    ack_drv = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk2); #1;
      if (!bus.req) begin fell = 1; break; end
    end
    ack_drv = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk2); #1;
      if (bus.req) begin rose = 1; break; end
    end
    chk({nm, "_fell"}, int'(fell), 1);
    chk({nm, "_rose"}, int'(rose), 1);
  endtask

  task automatic drain(input string nm, input int start_pend, input int budget);
    int prev = start_pend;
    bit done = 0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk2); #1;
      if (!bus.busy) begin done = 1; break; end
      if (int'(bus.pend_cnt) != prev) begin
        chk({nm, "_step"},     int'(bus.pend_cnt), prev - 1);
        chk({nm, "_relaunch"}, int'(bus.req),      1);
        prev = int'(bus.pend_cnt);
      end
    end
    chk({nm, "_done"}, int'(done), 1);
    chk({nm, "_pend0"}, int'(bus.pend_cnt), 0);
    $display("[TB] %s drained from %0d pending", nm, start_pend);
  endtask

  initial begin
    int r0;
    bit seen;

    // sig, ack, clr | req, busy, pend, ovf
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1, 1, 1, 0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1, 1, 2, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1, 1, 2, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 0, 1, 2, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 0, 1, 2, 0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 0, 1, 3, 0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1, 1, 3, 0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1, 1, 3, 0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1, 1, 3, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 0, 1, 3, 0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 0, 1, 3, 0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1, 1, 2, 0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1, 1, 3, 0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1, 1, 4, 0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1, 1, 5, 0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1, 1, 6, 0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1, 1, 7, 0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1, 1, 7, 1};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 1, 1, 7, 1};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 1, 1, 7, 0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1, 1, 7, 0};

    rstn        = 1'b0;
    bus.sig_in  = 1'b0;
    bus.ovf_clr = 1'b0;
    repeat (2) @(posedge clk2);
    #1;
    check_outs("reset", 0, 0, 0, 0);
    @(negedge clk2);
    rstn = 1'b1;

    // Cycle-exact table with ack driven directly (FSM sees ack two edges late).
    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].sig, vecs[i].ack, vecs[i].clr);
      check_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].busy, vecs[i].pend, vecs[i].ovf);
      $display("[TB] vec %0d sig=%0b ack=%0b clr=%0b -> req=%0b busy=%0b pend=%0d ovf=%0b",
               i, vecs[i].sig, vecs[i].ack, vecs[i].clr, bus.req, bus.busy, bus.pend_cnt, bus.ovf);
    end

    @(negedge clk2);
    rstn = 1'b0;
    bus.sig_in = 1'b0; bus.ovf_clr = 1'b0; ack_drv = 1'b0;
    repeat (2) @(negedge clk2);
    rstn = 1'b1;

    // Simultaneous: sig_in in the cycle ack_sync falls, with two pending.
    cyc(1'b1, 1'b0, 1'b0); check_outs("sim_e0", 1, 1, 0, 0);
    cyc(1'b1, 1'b0, 1'b0); check_outs("sim_e1", 1, 1, 1, 0);
    cyc(1'b1, 1'b0, 1'b0); check_outs("sim_e2", 1, 1, 2, 0);
    cyc(1'b0, 1'b1, 1'b0); check_outs("sim_e3", 1, 1, 2, 0);
    cyc(1'b0, 1'b1, 1'b0); check_outs("sim_e4", 1, 1, 2, 0);
    cyc(1'b0, 1'b0, 1'b0); check_outs("sim_e5", 0, 1, 2, 0);
    cyc(1'b0, 1'b0, 1'b0); check_outs("sim_e6", 0, 1, 2, 0);
    cyc(1'b1, 1'b0, 1'b0); check_outs("sim_e7", 1, 1, 2, 0);
    $display("[TB] simultaneous relaunch pend=%0d", bus.pend_cnt);

    // Build REQ_HI with pend=5 and ovf=1, then reset asynchronously.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check_outs("fill", 1, 1, 7, 1);
    handshake_direct("hs1");
    handshake_direct("hs2");
    check_outs("prerst", 1, 1, 5, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_outs("rst_async", 0, 0, 0, 0);
    $display("[TB] async reset mid-handshake req=%0b pend=%0d", bus.req, bus.pend_cnt);
    use_model = 1'b1;
    repeat (2) @(negedge clk2);
    rstn = 1'b1;

    // Single event through the slow-side model.
    r0 = rises;
    cyc(1'b1, 1'b0, 1'b0);
    check_outs("single_launch", 1, 1, 0, 0);
    @(negedge clk2);
    bus.sig_in = 1'b0;
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk2);
      if (bus.ack_async) begin seen = 1; break; end
    end
    chk("single_ack_seen", int'(seen), 1);
    @(posedge clk2); #1;
    chk("single_req_edge2", int'(bus.req), 1);
    @(posedge clk2); #1;
    chk("single_req_edge3", int'(bus.req), 0);
    drain("single", 0, 500);
    chk("single_rises", rises - r0, 1);

    // Burst of four back-to-back events.
    r0 = rises;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk($sformatf("burst_q%0d", i), int'(bus.pend_cnt), i);
    end
    @(negedge clk2);
    bus.sig_in = 1'b0;
    drain("burst", 3, 1000);
    chk("burst_rises", rises - r0, 4);

    // Overflow: one launch, seven queued, the ninth pulse is dropped.
    r0 = rises;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk($sformatf("ovf_q%0d", i), int'(bus.pend_cnt), (i > 7) ? 7 : i);
      chk($sformatf("ovf_f%0d", i), int'(bus.ovf), (i >= 8) ? 1 : 0);
    end
    @(negedge clk2);
    bus.sig_in = 1'b0;
    drain("ovf", 7, 2000);
    chk("ovf_rises", rises - r0, 8);
    chk("ovf_sticky", int'(bus.ovf), 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("ovf_clear", int'(bus.ovf), 0);
    @(negedge clk2);
    bus.ovf_clr = 1'b0;
    $display("[TB] overflow sequence handshakes=%0d", rises - r0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fast2slow_tx.md
Name: fast2slow_tx

Overview:
- Fast-domain (clk2) sending end of a 4-phase req/ack handshake that carries single-cycle events from the fast domain to the slow domain.
- It converts each clk2 pulse into one full handshake: level req, wait for synchronized ack high, drop req, wait for ack low.
- Events arriving while a handshake is in flight are counted and replayed back-to-back; overflow is flagged.
- Pairs with a slow-domain receiver that holds ack equal to its synchronized copy of req.

Parameters:
- SYNC_STAGES, 2, number of flops in the ack synchronizer chain (minimum 2).
- CW, 3, width of the pending-event counter; maximum pending count is 2^CW-1.

Ports:
- clk2  input  1  fast-domain clock.
- rstn  input  1  asynchronous, active-low reset.
- sig_in  input  1  single-cycle event pulse, clk2 domain.
- ack_async  input  1  ack from slow-domain receiver, asynchronous to clk2.
- ovf_clr  input  1  single-cycle clear of the sticky overflow flag.
- req  output  1  registered handshake request to the slow domain.
- busy  output  1  high whenever state is not IDLE.
- pend_cnt  output  CW  events accepted but not yet launched.
- ovf  output  1  sticky flag: an event was dropped.

Behaviour:
- Reset (async, rstn=0): req=0, busy=0, pend_cnt=0, ovf=0, state=IDLE, all synchronizer flops cleared. Reset mid-handshake abandons it. The slow side shares rstn, so no partial handshake survives.
- ack_sync is the last stage of a SYNC_STAGES-flop chain on ack_async. The FSM uses only ack_sync.
- FSM states: IDLE, REQ_HI, ACK_LO. req is a registered output, 1 exactly when state is REQ_HI.
- IDLE: launch when sig_in=1 or pend_cnt>0. Next state is REQ_HI, so req=1 on the following edge. Latency from sig_in to req is 1 clk2 edge.
- REQ_HI: hold req=1 until ack_sync=1, then go to ACK_LO (req=0 on that edge).
- ACK_LO: wait for ack_sync=0. If pend_cnt>0, or sig_in is 1 that cycle, go directly to REQ_HI (launch). Otherwise go to IDLE.
- ack_sync=1 while in IDLE (protocol violation) is ignored, and a launch is not blocked. Bench flags it with an assertion.
- Launch priority: a launch consumes a pending event first when pend_cnt>0; otherwise it consumes the same-cycle sig_in.
- pend_cnt update per cycle, with inc = sig_in not consumed by a launch and dec = launch from pending:
  - inc only: +1.
  - dec only: -1.
  - both: unchanged.
- Saturation: when inc is due and pend_cnt = 2^CW-1, the count is held, the event is dropped, and ovf is set on the next edge.
- ovf is sticky. ovf_clr clears it next edge. If set and clear occur in the same cycle, set wins (ovf stays 1).
- One handshake per event, no coalescing. Total handshakes = accepted events.
- Minimum handshake period is 2*(SYNC_STAGES+1) clk2 cycles plus slow-domain latency.

Decomposition:
- Shared package fast2slow_pkg holds:
  - FSM state encodings (IDLE=2'd0, REQ_HI=2'd1, ACK_LO=2'd2).
  - Default SYNC_STAGES.
- Natural sub-module: sync_cell, a parameterised SYNC_STAGES-deep single-bit synchronizer with async active-low reset. It is reused by the slow-domain receiver for req.

Test Plan (SYNC_STAGES=2, CW=3; receiver model returns ack = req delayed 4 slow cycles):
- Single event: sig_in pulse at edge 0 -> req=1 and busy=1 after edge 1; req falls on the 3rd clk2 edge after ack_async rises; busy=0 once ack_sync returns low; pend_cnt stays 0.
- Burst: 4 sig_in pulses on consecutive cycles from IDLE -> first launches immediately; pend_cnt reaches 3, then counts 3->2->1->0 at each relaunch from ACK_LO; exactly 4 req rising edges; no IDLE gap between them.
- Overflow: 9 pulses while busy -> pend_cnt saturates at 7 and ovf=1 after the 8th queued attempt; exactly 8 total handshakes (1 in flight + 7 pending).
- Simultaneous: sig_in=1 in the ACK_LO cycle where ack_sync falls, with pend_cnt=2 -> relaunch from pending; pend_cnt stays 2.
- ovf_clr collision: ovf_clr=1 in the same cycle as a dropped event -> ovf remains 1. A later lone ovf_clr -> ovf=0 next edge.
- Reset mid-operation: rstn low while in REQ_HI with pend_cnt=5, ovf=1 -> req, busy, pend_cnt and ovf are 0 immediately (asynchronously). After release, a fresh sig_in completes a normal handshake.
